// File: rtl/mem_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter_pkg
//  Description : Shared types and defaults for the unified memory port arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        ISSUE  = 2'b01,
        WAIT   = 2'b10,
        HALTED = 2'b11
    } arb_state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    localparam int c_starve_max_def = 4;
    localparam int c_timeout_def    = 15;

    // Bits needed to hold 0..max_val (never less than one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_timer.sv
`default_nettype none
// ============================================================================
//  Module      : mem_arb_timer
//  Description : Loadable saturating up-counter with clear, enable and a
//                terminal-count flag raised while the count equals MAX.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_arb_timer #(
    parameter int WIDTH = 4,
    parameter int MAX   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_tc
);

    localparam logic [WIDTH-1:0] c_max = WIDTH'(MAX);

    logic [WIDTH-1:0] r_count;

    // Clear beats load beats count; a load above MAX is clamped to MAX.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= (i_load_val > c_max) ? c_max : i_load_val;
        end else if (i_en && (r_count != c_max)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_tc = (r_count == c_max);

endmodule
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : mem_port_arbiter
//  Description : Shares one single-ported memory between fetch and data
//                requesters, with starvation guard, timeout and halt drain.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = c_starve_max_def,
    parameter int TIMEOUT    = c_timeout_def
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_done,
    output logic        if_stall,
    input  logic        dm_rd,
    input  logic        dm_wr,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_wdata,
    output logic [15:0] dm_rdata,
    output logic        dm_done,
    output logic        dm_stall,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ready,
    input  logic        halt,
    output logic        idle,
    output logic        err
);

    localparam int c_starve_w = cnt_width(STARVE_MAX);
    localparam int c_timer_w  = cnt_width(TIMEOUT - 1);

    arb_state_t  r_state;
    arb_state_t  w_state_nxt;
    logic        r_owner;
    logic        r_wr;
    logic [15:0] r_addr;
    logic [15:0] r_wdata;
    logic [15:0] r_if_rdata;
    logic [15:0] r_dm_rdata;
    logic        r_if_done;
    logic        r_dm_done;
    logic        r_err;

    logic w_dm_req;
    logic w_dm_bad;
    logic w_decide;
    logic w_dm_errack;
    logic w_grant_if;
    logic w_grant_dm;
    logic w_complete;
    logic w_timeout;
    logic w_starve_tc;
    logic w_timer_tc;

    // No decision is taken in a cycle where a done pulse is out, so the
    // requester that just finished cannot be re-granted on a stale request.
    assign w_dm_req    = dm_rd | dm_wr;
    assign w_dm_bad    = w_dm_req & ((dm_rd & dm_wr) | dm_addr[0]);
    assign w_decide    = (r_state == IDLE) & ~halt & ~r_if_done & ~r_dm_done;
    assign w_dm_errack = w_decide & w_dm_bad;
    assign w_grant_if  = w_decide & ~w_dm_bad & if_req & (w_starve_tc | ~w_dm_req);
    assign w_grant_dm  = w_decide & ~w_dm_bad & w_dm_req & ~(w_starve_tc & if_req);
    assign w_complete  = (r_state == WAIT) & mem_ready;
    assign w_timeout   = (r_state == WAIT) & ~mem_ready & w_timer_tc;

    mem_arb_timer #(
        .WIDTH (c_starve_w),
        .MAX   (STARVE_MAX)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_decide & (w_grant_if | ~if_req)),
        .i_en       (w_grant_dm & if_req),
        .i_load     (1'b0),
        .i_load_val ({c_starve_w{1'b0}}),
        .o_tc       (w_starve_tc)
    );

    // Terminal count at TIMEOUT-1 marks the last WAIT cycle before expiry.
    mem_arb_timer #(
        .WIDTH (c_timer_w),
        .MAX   (TIMEOUT - 1)
    ) u_timeout (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (r_state == ISSUE),
        .i_en       (r_state == WAIT),
        .i_load     (1'b0),
        .i_load_val ({c_timer_w{1'b0}}),
        .o_tc       (w_timer_tc)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (halt) begin
                    w_state_nxt = HALTED;
                end else if (w_grant_if | w_grant_dm) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: w_state_nxt = WAIT;
            WAIT: begin
                if (w_complete) begin
                    w_state_nxt = halt ? HALTED : IDLE;
                end else if (w_timeout) begin
                    w_state_nxt = IDLE;
                end
            end
            HALTED:  w_state_nxt = HALTED;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_owner    <= OWN_IF;
            r_wr       <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_if_rdata <= '0;
            r_dm_rdata <= '0;
            r_if_done  <= 1'b0;
            r_dm_done  <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_if_done <= 1'b0;
            r_dm_done <= 1'b0;
            if (w_dm_errack) begin
                r_err      <= 1'b1;
                r_dm_rdata <= '0;
                r_dm_done  <= 1'b1;
            end
            // A misaligned fetch is still served, from the aligned word.
            if (w_grant_if) begin
                r_owner <= OWN_IF;
                r_addr  <= {if_addr[15:1], 1'b0};
                r_wr    <= 1'b0;
                if (if_addr[0]) begin
                    r_err <= 1'b1;
                end
            end
            if (w_grant_dm) begin
                r_owner <= OWN_DM;
                r_addr  <= dm_addr;
                r_wdata <= dm_wdata;
                r_wr    <= dm_wr;
            end
            if (w_complete) begin
                if (r_owner == OWN_IF) begin
                    r_if_rdata <= mem_rdata;
                    r_if_done  <= 1'b1;
                end else begin
                    if (!r_wr) begin
                        r_dm_rdata <= mem_rdata;
                    end
                    r_dm_done <= 1'b1;
                end
            end
            if (w_timeout) begin
                r_err <= 1'b1;
                if (r_owner == OWN_IF) begin
                    r_if_rdata <= '0;
                    r_if_done  <= 1'b1;
                end else begin
                    r_dm_rdata <= '0;
                    r_dm_done  <= 1'b1;
                end
            end
        end
    end

    assign if_rdata  = r_if_rdata;
    assign if_done   = r_if_done;
    assign if_stall  = if_req & ~r_if_done;
    assign dm_rdata  = r_dm_rdata;
    assign dm_done   = r_dm_done;
    assign dm_stall  = w_dm_req & ~r_dm_done;
    assign mem_en    = (r_state == ISSUE);
    assign mem_wr    = (r_state == ISSUE) & r_wr;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign idle      = (r_state == IDLE) | (r_state == HALTED);
    assign err       = r_err;

endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Arbitrates one shared single-ported unified memory between the fetch stage (instruction reads) and the memory stage (data reads/writes) of the 5-stage pipeline.
- Latches each granted request, issues it to memory, waits for a variable-latency completion, and returns data and a done pulse to the winner.
- Its per-requester stall outputs feed the pipeline stall logic.
- Also handles halt draining, starvation protection and error trapping; `err` is ORed into the processor `err`.

Parameters:
- STARVE_MAX, 4: consecutive data grants while fetch waits before fetch is forced to win.
- TIMEOUT, 15: cycles allowed from issue to mem_ready before error.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- if_req  in  1  fetch read request; held until if_done
- if_addr  in  16  fetch address
- if_rdata  out  16  fetched word; registered, valid with if_done, held until next if_done
- if_done  out  1  one-cycle completion pulse to fetch
- if_stall  out  1  if_req & ~if_done
- dm_rd  in  1  data read request; held until dm_done
- dm_wr  in  1  data write request; held until dm_done
- dm_addr  in  16  data address
- dm_wdata  in  16  data write value
- dm_rdata  out  16  read data; registered, held until next dm_done
- dm_done  out  1  one-cycle completion pulse to memory stage
- dm_stall  out  1  (dm_rd|dm_wr) & ~dm_done
- mem_en  out  1  one-cycle issue strobe to memory
- mem_wr  out  1  write qualifier, valid with mem_en
- mem_addr  out  16  latched address, held from issue until completion
- mem_wdata  out  16  latched write data, held from issue until completion
- mem_rdata  in  16  memory read data, valid with mem_ready
- mem_ready  in  1  one-cycle completion from memory
- halt  in  1  stop granting after draining
- idle  out  1  no access in flight
- err  out  1  sticky error

Behaviour:
- Reset values: all outputs 0, except idle=1. State=IDLE, starve_cnt=0, timer=0.
- States: IDLE, ISSUE, WAIT, HALTED.
- IDLE, halt=1: go to HALTED. No new grant is made.
- IDLE, decision order:
  - error checks on the data request come first (below);
  - if starve_cnt==STARVE_MAX and if_req: grant fetch;
  - else if dm_rd|dm_wr: grant data;
  - else if if_req: grant fetch.
- On a grant: latch owner, addr, wdata and wr (wr=dm_wr for data, 0 for fetch). Go to ISSUE.
- ISSUE: mem_en=1 for exactly this cycle. timer cleared. Go to WAIT.
- WAIT: timer increments each cycle.
  - On mem_ready: capture mem_rdata into the owner's rdata register (fetch, or data read only). Pulse the owner's done next cycle. Go to IDLE, or to HALTED if halt.
  - A data write leaves dm_rdata unchanged.
- Grant-to-done latency is 3 cycles minimum, when mem_ready arrives the cycle after ISSUE. The completed requester is not re-granted in the cycle its done pulses.
- Starvation counter:
  - starve_cnt increments, saturating at STARVE_MAX, on each data grant made while if_req=1.
  - Cleared on any fetch grant, or when if_req=0 at a decision.
- Error cases:
  - Data request with dm_rd & dm_wr both 1: err=1, no memory access, dm_done pulsed with dm_rdata=0.
  - Data request with dm_addr[0]=1: same response as above.
  - Fetch request with if_addr[0]=1: err=1, access still issued with address bit 0 forced to 0.
  - timer reaches TIMEOUT in WAIT: err=1, owner's done pulsed with rdata=0, return to IDLE.
- err stays 1 until reset.
- HALTED: absorbing; only reset exits. Requests are ignored and stall outputs stay asserted while requests are held. idle=1.
- idle=1 in IDLE and HALTED, 0 in ISSUE and WAIT.
- mem_ready outside WAIT is ignored.
- A requester dropping its request mid-access does not abort the access; the done pulse is still produced.
- Reset asserted mid-access: immediate return to reset values; the in-flight access is abandoned.

Decomposition:
- Shared package holds:
  - state encoding: IDLE=2'b00, ISSUE=2'b01, WAIT=2'b10, HALTED=2'b11;
  - owner encoding: OWN_IF=1'b0, OWN_DM=1'b1;
  - default STARVE_MAX and TIMEOUT.
- One sub-module, mem_arb_timer: a loadable saturating counter with clear, enable and a terminal-count flag. It is instantiated twice, once for the starvation count and once for the timeout.

Test Plan:
- Reset, then if_req with if_addr=0x0010; mem_ready 2 cycles after mem_en with mem_rdata=0xBEEF. Required: mem_en one cycle with mem_addr=0x0010, mem_wr=0; if_done pulses once; if_rdata=0xBEEF; err=0.
- if_req and dm_wr held together, dm_addr=0x0100, dm_wdata=0x1234. Required: data granted first (mem_wr=1, mem_addr=0x0100, mem_wdata=0x1234); dm_done, then a fetch issue; dm_rdata unchanged.
- dm_rd held continuously and if_req held. Required: exactly 4 data grants, then one fetch grant, then the pattern repeats.
- dm_rd=dm_wr=1 at dm_addr=0x0002, followed by a separate dm_rd at dm_addr=0x0003. Required: no mem_en for either; dm_done pulses with dm_rdata=0; err=1 and stays 1.
- Data read issued, mem_ready never returns. Required: 15 cycles in WAIT, then err=1, dm_done with dm_rdata=0, idle=1.
- halt asserted during WAIT. Required: the access completes with its done pulse, state HALTED, and no further mem_en despite held requests. Then rst=0 mid-cycle: all outputs immediately at reset values.
